picosoc_timer: RTL and testbench



---
 rtl/picosoc_timer_pkg.sv | 28 ++
 rtl/picosoc_timer_prescaler.sv | 29 ++
 rtl/picosoc_timer.sv | 133 +++++++++++++
 tb/tb_picosoc_timer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/picosoc_timer_pkg.sv
// Shared register map, bit positions and byte-merge helper for the
// PicoSoC down-counting timer peripheral.
package picosoc_timer_pkg;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_PRESCALE = 8'h04;
    localparam logic [7:0] OFF_COUNT    = 8'h08;
    localparam logic [7:0] OFF_RELOAD   = 8'h0C;
    localparam logic [7:0] OFF_STATUS   = 8'h10;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IE       = 2;

    localparam int STATUS_EXPIRED = 0;

    // Replace only the bytes of old_val whose write strobe is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = wstrb[i] ? wdata[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/picosoc_timer_prescaler.sv
// 16-bit prescaler: emits a one-cycle tick every PRESCALE+1 enabled cycles.
module picosoc_timer_prescaler
    import picosoc_timer_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic        clear,
    input  logic [15:0] prescale,
    output logic        tick
);

    logic [15:0] pcnt;

    assign tick = en && (pcnt == prescale);

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcnt <= '0;
        end else if (!en || clear || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 16'd1;
        end
    end

endmodule

// File: rtl/picosoc_timer.sv
// Memory-mapped timer on the PicoSoC iomem bus: prescaler, 32-bit
// down-counter with one-shot/periodic reload and a sticky expiry interrupt.
module picosoc_timer
    import picosoc_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    logic [2:0]  ctrl, ctrl_d;
    logic [15:0] prescale, prescale_d;
    logic [31:0] count, count_d;
    logic [31:0] reload, reload_d;
    logic        expired, expired_d;

    logic        sel, wr;
    logic [7:0]  off;
    logic        wr_ctrl, wr_prescale, wr_count, wr_reload, wr_status;
    logic        en_rise, tick, expire;
    logic [31:0] rdata_mux;

    assign off = iomem_addr[7:0];
    assign sel = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);

    // Writes commit on the edge that closes the ready-high cycle.
    assign wr          = iomem_ready && sel && (iomem_wstrb != 4'b0000);
    assign wr_ctrl     = wr && (off == OFF_CTRL);
    assign wr_prescale = wr && (off == OFF_PRESCALE);
    assign wr_count    = wr && (off == OFF_COUNT);
    assign wr_reload   = wr && (off == OFF_RELOAD);
    assign wr_status   = wr && (off == OFF_STATUS);

    assign en_rise = wr_ctrl && iomem_wstrb[0] && iomem_wdata[CTRL_EN] && !ctrl[CTRL_EN];

    picosoc_timer_prescaler u_prescaler (
        .clk      (clk),
        .resetn   (resetn),
        .en       (ctrl[CTRL_EN]),
        .clear    (en_rise),
        .prescale (prescale),
        .tick     (tick)
    );

    assign expire = tick && (count == 32'd0);

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        ctrl_d     = ctrl;
        prescale_d = prescale;
        count_d    = count;
        reload_d   = reload;
        expired_d  = expired;

        if (tick) begin
            if (count != 32'd0) begin
                count_d = count - 32'd1;
            end else if (ctrl[CTRL_PERIODIC]) begin
                count_d = reload;
            end else begin
                count_d = '0;
                ctrl_d[CTRL_EN] = 1'b0;
            end
        end

        // Bus writes take priority over the counter's own update.
        if (wr_ctrl && iomem_wstrb[0]) begin
            ctrl_d = iomem_wdata[2:0];
        end
        if (wr_prescale) begin
            for (int i = 0; i < 2; i++) begin
                if (iomem_wstrb[i]) prescale_d[i*8 +: 8] = iomem_wdata[i*8 +: 8];
            end
        end
        if (wr_count) begin
            count_d = merge_bytes(count, iomem_wdata, iomem_wstrb);
        end
        if (wr_reload) begin
            reload_d = merge_bytes(reload, iomem_wdata, iomem_wstrb);
        end

        // A fresh expiry outranks a simultaneous W1C.
        if (wr_status && iomem_wstrb[0] && iomem_wdata[STATUS_EXPIRED]) begin
            expired_d = 1'b0;
        end
        if (expire) begin
            expired_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            ctrl        <= '0;
            prescale    <= '0;
            count       <= '0;
            reload      <= '0;
            expired     <= 1'b0;
        end else begin
            iomem_ready <= sel && !iomem_ready;
            ctrl        <= ctrl_d;
            prescale    <= prescale_d;
            count       <= count_d;
            reload      <= reload_d;
            expired     <= expired_d;
        end
    end

    always_comb begin
        rdata_mux = '0;
        case (off)
            OFF_CTRL:     rdata_mux = {29'd0, ctrl};
            OFF_PRESCALE: rdata_mux = {16'd0, prescale};
            OFF_COUNT:    rdata_mux = count;
            OFF_RELOAD:   rdata_mux = reload;
            OFF_STATUS:   rdata_mux = {31'd0, expired};
            default:      rdata_mux = '0;
        endcase
    end

    assign iomem_rdata = iomem_ready ? rdata_mux : 32'd0;
    assign irq         = expired && ctrl[CTRL_IE];

endmodule

// File: tb/tb_picosoc_timer.sv
// Scoreboard bench for picosoc_timer: expected read data is queued when a
// read is issued and compared when the DUT acknowledges it.
module tb_picosoc_timer;
    import picosoc_timer_pkg::*;

    localparam logic [31:0] BASE = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic [3:0]  iomem_wstrb = 4'b0;
    logic [31:0] iomem_addr = 32'd0;
    logic [31:0] iomem_wdata = 32'd0;
    logic        iomem_ready;
    logic [31:0] iomem_rdata;
    logic        irq;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    picosoc_timer #(.BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .irq         (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one request, hold it through the committing edge, then release.
    task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] strb,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output logic acked, output int lat);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = wdata;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!iomem_ready && lat < 20);
        acked = iomem_ready;
        rdata = iomem_rdata;
        if (acked) begin
            @(posedge clk);
            #1;
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0;
    endtask

    task automatic bus_write(input string tag, input logic [7:0] off,
                             input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] rd;
        logic        ack;
        int          lat;
        bus_xfer(BASE + {24'd0, off}, strb, data, rd, ack, lat);
        check({tag, "_ack"}, {31'd0, ack}, 32'd1);
    endtask

    task automatic bus_read(input string tag, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        logic        ack;
        int          lat;
        logic [31:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus_xfer(BASE + {24'd0, off}, 4'b0, 32'd0, rd, ack, lat);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, "_ack"}, {31'd0, ack}, 32'd1);
        check({t, "_lat"}, lat, 32'd1);
        if (ack) check(t, rd, e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        ack;
        int          lat;

        // Reset state
        wait_edges(3);
        check("rst_ready", {31'd0, iomem_ready}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rdata", iomem_rdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        bus_read("rst_ctrl",     OFF_CTRL,     32'd0);
        bus_read("rst_prescale", OFF_PRESCALE, 32'd0);
        bus_read("rst_count",    OFF_COUNT,    32'd0);
        bus_read("rst_reload",   OFF_RELOAD,   32'd0);
        bus_read("rst_status",   OFF_STATUS,   32'd0);
        check("idle_rdata", iomem_rdata, 32'd0);

        // Byte strobes and unused offsets
        bus_write("rl_full", OFF_RELOAD, 32'h1122_3344, 4'b1111);
        bus_write("rl_part", OFF_RELOAD, 32'hAABB_CCDD, 4'b0101);
        bus_read("rl_strb", OFF_RELOAD, 32'h11BB_33DD);
        bus_write("unused_wr", 8'h20, 32'hFFFF_FFFF, 4'b1111);
        bus_read("unused_rd", 8'h20, 32'd0);

        // One-shot: expiry (5+1)*(3+1) = 24 cycles after enable commits
        bus_write("os_pre", OFF_PRESCALE, 32'd3, 4'b1111);
        bus_write("os_cnt", OFF_COUNT, 32'd5, 4'b1111);
        bus_write("os_ctrl", OFF_CTRL, 32'h5, 4'b1111);
        wait_edges(23);
        check("os_irq_early", {31'd0, irq}, 32'd0);
        wait_edges(1);
        check("os_irq", {31'd0, irq}, 32'd1);
        bus_read("os_status", OFF_STATUS, 32'd1);
        bus_read("os_ctrl_rd", OFF_CTRL, 32'h4);
        bus_read("os_count_rd", OFF_COUNT, 32'd0);
        bus_write("os_w1c", OFF_STATUS, 32'd1, 4'b1111);
        check("os_irq_clr", {31'd0, irq}, 32'd0);
        bus_read("os_status_clr", OFF_STATUS, 32'd0);

        // Periodic: expiry every 10 cycles, W1C collision at the third one
        bus_write("pd_pre", OFF_PRESCALE, 32'd0, 4'b1111);
        bus_write("pd_rl", OFF_RELOAD, 32'd9, 4'b1111);
        bus_write("pd_cnt", OFF_COUNT, 32'd9, 4'b1111);
        bus_write("pd_ctrl", OFF_CTRL, 32'h7, 4'b1111);
        wait_edges(9);
        check("pd_irq_early1", {31'd0, irq}, 32'd0);
        wait_edges(1);
        check("pd_irq1", {31'd0, irq}, 32'd1);
        bus_write("pd_w1c1", OFF_STATUS, 32'd1, 4'b1111);
        check("pd_irq_clr1", {31'd0, irq}, 32'd0);
        wait_edges(7);
        check("pd_irq_early2", {31'd0, irq}, 32'd0);
        wait_edges(1);
        check("pd_irq2", {31'd0, irq}, 32'd1);
        bus_write("pd_w1c2", OFF_STATUS, 32'd1, 4'b1111);
        check("pd_irq_clr2", {31'd0, irq}, 32'd0);
        wait_edges(6);
        bus_write("pd_w1c_coll", OFF_STATUS, 32'd1, 4'b1111);
        check("pd_w1c_vs_expiry", {31'd0, irq}, 32'd1);

        // COUNT write on the same edge as a tick
        bus_write("cc_stop", OFF_CTRL, 32'h0, 4'b1111);
        bus_write("cc_w1c", OFF_STATUS, 32'd1, 4'b1111);
        bus_write("cc_pre", OFF_PRESCALE, 32'd7, 4'b1111);
        bus_write("cc_cnt", OFF_COUNT, 32'd200, 4'b1111);
        bus_write("cc_ctrl", OFF_CTRL, 32'h1, 4'b1111);
        wait_edges(6);
        bus_write("cc_cnt_coll", OFF_COUNT, 32'd100, 4'b1111);
        bus_read("cc_count_rd", OFF_COUNT, 32'd100);
        bus_write("cc_stop2", OFF_CTRL, 32'h0, 4'b1111);

        // Out-of-window accesses: no ready, no side effects
        bus_xfer(32'h0400_0000, 4'b0, 32'd0, rd, ack, lat);
        check("oow_rd_ready", {31'd0, ack}, 32'd0);
        bus_xfer(32'h0400_0008, 4'b1111, 32'hDEAD_BEEF, rd, ack, lat);
        check("oow_wr_ready", {31'd0, ack}, 32'd0);
        bus_read("oow_count", OFF_COUNT, 32'd100);

        // Reset during a pending in-window write
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = BASE + 32'(OFF_RELOAD);
        iomem_wstrb = 4'b1111;
        iomem_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        check("mid_ready", {31'd0, iomem_ready}, 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, iomem_ready}, 32'd0);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0;
        wait_edges(2);
        @(negedge clk);
        resetn = 1'b1;
        bus_read("mid_reload", OFF_RELOAD, 32'd0);
        bus_read("mid_count", OFF_COUNT, 32'd0);
        check("mid_irq", {31'd0, irq}, 32'd0);

        check("sb_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
